// File: rtl/customer_dispense_if.sv
// Signal bundle between the customer purchase path and the rest of the machine:
// mode/coin/selection strobes in, supply array read/write-back and customer outputs.
interface customer_dispense_if;
   logic [1:0] mode;
   logic       coin_valid;
   logic [1:0] coin;
   logic       select_valid;
   logic [1:0] select;
   logic       cancel;
   logic [3:0] supply;
   logic [1:0] slot_addr;
   logic [3:0] supply_out;
   logic       dispense;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       coin_reject;
   logic       redLight;
   logic       needMore;
   logic [7:0] credit;
   logic [2:0] dbg_state;

   modport slave (
      input  mode, coin_valid, coin, select_valid, select, cancel, supply,
      output slot_addr, supply_out, dispense, change_valid, change_coin,
             coin_reject, redLight, needMore, credit, dbg_state
   );

   modport master (
      output mode, coin_valid, coin, select_valid, select, cancel, supply,
      input  slot_addr, supply_out, dispense, change_valid, change_coin,
             coin_reject, redLight, needMore, credit, dbg_state
   );
endinterface

// File: rtl/customer_dispense.sv
// Customer purchase path: coin credit, stock/price check, slot decrement and greedy change.
// Optional refund button enabled by defining CANCEL_EN.
module customer_dispense #(
   parameter logic [3:0] PRICE0 = 4'd3,
   parameter logic [3:0] PRICE1 = 4'd5,
   parameter logic [3:0] PRICE2 = 4'd7,
   parameter logic [3:0] PRICE3 = 4'd10
) (
   input logic                clk,
   input logic                rst,
   customer_dispense_if.slave bus
);
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_COLLECT  = 3'd1;
   localparam logic [2:0] S_CHECK    = 3'd2;
   localparam logic [2:0] S_DISPENSE = 3'd3;
   localparam logic [2:0] S_CHANGE   = 3'd4;

   // Handshake: coin_valid, select_valid and cancel are one-cycle requests sampled on the
   // rising edge with no ready; a request the block cannot take is dropped, and a dropped
   // coin is reported by a coin_reject pulse in the following cycle.
   logic [2:0] state;
   logic [7:0] credit;
   logic [1:0] slot_addr;
   logic [3:0] supply_out;
   logic       dispense;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       coin_reject;
   logic       red_light;
   logic       need_more;

   logic       buy;
   logic       refund_req;
   logic [3:0] coin_units;
   logic [8:0] credit_sum;
   logic       coin_ok;
   logic [3:0] price;
   logic [1:0] chg_code;
   logic [7:0] chg_units;
   logic [7:0] credit_left;

   assign buy = (bus.mode == 2'b01);

`ifdef CANCEL_EN
   assign refund_req = !buy || bus.cancel;
`else
   logic unused_cancel;
   assign unused_cancel = bus.cancel;
   assign refund_req    = !buy;
`endif

   always_comb begin
      coin_units = 4'd0;
      case (bus.coin)
         2'b01:   coin_units = 4'd1;
         2'b10:   coin_units = 4'd2;
         2'b11:   coin_units = 4'd5;
         default: coin_units = 4'd0;
      endcase
   end

   // Ninth bit of the sum flags a coin that would push credit past 255.
   assign credit_sum = {1'b0, credit} + {5'd0, coin_units};
   assign coin_ok    = (bus.coin != 2'b00) && !credit_sum[8];

   always_comb begin
      price = PRICE0;
      case (slot_addr)
         2'd1:    price = PRICE1;
         2'd2:    price = PRICE2;
         2'd3:    price = PRICE3;
         default: price = PRICE0;
      endcase
   end

   always_comb begin
      chg_code  = 2'b01;
      chg_units = 8'd1;
      if (credit >= 8'd5) begin
         chg_code  = 2'b11;
         chg_units = 8'd5;
      end else if (credit >= 8'd2) begin
         chg_code  = 2'b10;
         chg_units = 8'd2;
      end
   end

   assign credit_left = credit - chg_units;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         credit       <= 8'd0;
         slot_addr    <= 2'd0;
         supply_out   <= 4'd0;
         dispense     <= 1'b0;
         change_valid <= 1'b0;
         change_coin  <= 2'b00;
         coin_reject  <= 1'b0;
         red_light    <= 1'b0;
         need_more    <= 1'b0;
      end else begin
         dispense     <= 1'b0;
         change_valid <= 1'b0;
         change_coin  <= 2'b00;
         coin_reject  <= 1'b0;
         supply_out   <= bus.supply;
         case (state)
            S_IDLE: begin
               if (bus.coin_valid) begin
                  if (buy && coin_ok) begin
                     credit    <= credit_sum[7:0];
                     red_light <= 1'b0;
                     need_more <= 1'b0;
                     state     <= S_COLLECT;
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (refund_req) begin
                  coin_reject <= bus.coin_valid;
                  state       <= (credit != 8'd0) ? S_CHANGE : S_IDLE;
               end else if (bus.coin_valid) begin
                  if (coin_ok) credit <= credit_sum[7:0];
                  else         coin_reject <= 1'b1;
                  if (coin_ok || bus.select_valid) begin
                     red_light <= 1'b0;
                     need_more <= 1'b0;
                  end
               end else if (bus.select_valid) begin
                  slot_addr <= bus.select;
                  red_light <= 1'b0;
                  need_more <= 1'b0;
                  state     <= S_CHECK;
               end
            end
            S_CHECK: begin
               coin_reject <= bus.coin_valid;
               if (bus.supply == 4'd0) begin
                  red_light <= 1'b1;
                  state     <= S_COLLECT;
               end else if (credit < {4'd0, price}) begin
                  need_more <= 1'b1;
                  state     <= S_COLLECT;
               end else begin
                  dispense   <= 1'b1;
                  supply_out <= bus.supply - 4'd1;
                  credit     <= credit - {4'd0, price};
                  state      <= S_DISPENSE;
               end
            end
            S_DISPENSE, S_CHANGE: begin
               // The first change coin leaves straight out of DISPENSE so coins follow it back to back.
               coin_reject <= bus.coin_valid;
               if (credit != 8'd0) begin
                  change_valid <= 1'b1;
                  change_coin  <= chg_code;
                  credit       <= credit_left;
                  state        <= (credit_left == 8'd0) ? S_IDLE : S_CHANGE;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.slot_addr    = slot_addr;
   assign bus.supply_out   = supply_out;
   assign bus.dispense     = dispense;
   assign bus.change_valid = change_valid;
   assign bus.change_coin  = change_coin;
   assign bus.coin_reject  = coin_reject;
   assign bus.redLight     = red_light;
   assign bus.needMore     = need_more;
   assign bus.credit       = credit;
   assign bus.dbg_state    = state;
endmodule

// File: doc/customer_dispense.md
# customer_dispense

Customer-side purchase path of the vending machine, the consuming counterpart of the owner charge path. In buy mode it accumulates inserted coins as credit, takes an item selection, checks stock and price, decrements the selected slot's supply count in the supply array, and returns change one coin per cycle. It reads the slot count from the array and drives the updated count back, with the same interface shape the owner charge path uses.

## Interface
- PRICE0, 4'd3: price of slot 0, in credit units
- PRICE1, 4'd5: price of slot 1
- PRICE2, 4'd7: price of slot 2
- PRICE3, 4'd10: price of slot 3
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  2  machine mode; 2'b01 = buy
- coin_valid  in  1  one-cycle coin strobe
- coin  in  2  coin code: 01 = 1, 10 = 2, 11 = 5 units; 00 is invalid
- select_valid  in  1  one-cycle selection strobe
- select  in  2  slot index
- cancel  in  1  refund request; only with CANCEL_EN
- supply  in  4  count of the slot on slot_addr, from the array
- slot_addr  out  2  slot addressed in the array
- supply_out  out  4  count written back to the array
- dispense  out  1  one-cycle pulse: the item is released
- change_valid  out  1  a change coin is presented this cycle
- change_coin  out  2  change coin code, same encoding as coin
- coin_reject  out  1  one-cycle pulse: the coin was not accepted
- redLight  out  1  selected slot is empty
- needMore  out  1  credit is below the selected price
- credit  out  8  current credit

## Operation
- States: IDLE, COLLECT, CHECK, DISPENSE, CHANGE.
- IDLE:
  - Waits for mode == 2'b01.
  - An accepted coin in buy mode moves to COLLECT.
- COLLECT:
  - Each coin_valid with a valid code adds its value to credit.
  - A coin with code 00 is rejected.
  - A coin that would make credit exceed 255 is rejected, and credit is unchanged.
  - select_valid latches the slot into slot_addr and moves to CHECK.
  - coin_valid has priority over select_valid in the same cycle; the selection is dropped.
- CHECK (one cycle; supply is valid for slot_addr):
  - supply == 0: set redLight and return to COLLECT. Credit is kept.
  - Otherwise, credit < price: set needMore and return to COLLECT.
  - Otherwise: go to DISPENSE.
- DISPENSE (one cycle):
  - supply_out = supply − 1.
  - dispense = 1.
  - credit = credit − price.
  - Go to CHANGE if credit > 0, else IDLE.
- CHANGE:
  - One coin per cycle, greedy order 5, then 2, then 1.
  - change_valid = 1 with that coin; credit decreases by the coin value.
  - Go to IDLE when credit reaches 0.
- Outside DISPENSE, supply_out = supply (registered pass-through). The block never underflows a slot.
- redLight and needMore clear on the next accepted coin or select_valid.
- Mode leaving 2'b01 while in COLLECT with credit > 0 goes to CHANGE (full refund). With credit 0 it goes to IDLE.
- Mode changes during CHECK, DISPENSE or CHANGE are ignored until the block is back in IDLE.
- Coins and selections are ignored in CHECK, DISPENSE and CHANGE; coin_reject pulses for any coin arriving there.

## Timing
- Reset values: state IDLE; credit 0; slot_addr 0; supply_out 0; all pulse outputs 0; redLight and needMore 0.
- Reset mid-operation aborts immediately. Credit is lost and no dispense or change is produced.
- Coin to credit update: 1 cycle.
- select_valid to dispense: 2 cycles (CHECK, then DISPENSE). supply_out updates on the same edge that dispense asserts.
- Change coins: consecutive cycles, starting the cycle after DISPENSE.
- All outputs are registered.

## Configuration
- CANCEL_EN defined: cancel in COLLECT moves to CHANGE and refunds the full credit. With credit 0 it goes to IDLE. cancel has priority over coin_valid and select_valid in the same cycle.
- CANCEL_EN undefined: the cancel input is ignored. Refund happens only when mode leaves 2'b01.

## Test plan
- mode 01; coins 5, then 2; select slot 1 (price 5), supply 4:
  - credit reads 7;
  - dispense pulses 2 cycles after the select;
  - supply_out reads 3;
  - one change coin of code 10 (2 units);
  - back to IDLE.
- Select slot 0 with supply 0 and credit 5: redLight = 1, no dispense, credit stays 5, state is COLLECT.
- Credit 2, select slot 2 (price 7): needMore = 1; add a 5 coin, reselect → dispense, no change.
- Credit 253 plus a 5 coin → coin_reject pulses and credit stays 253. Coin code 00 → coin_reject pulses.
- Credit 8, mode switched to 00 in COLLECT → change coins 5, 2, 1 on consecutive cycles, then IDLE. With CANCEL_EN, cancel gives the same result.
- rst asserted during CHANGE → all outputs return to their reset values immediately; change_valid stays 0 afterwards.
